// File: rtl/traffic_light_if.sv
// traffic_light_if
//   Bundles the tick/sensor inputs and lamp/select outputs of the
//   two-street traffic light controller.
//
//   tick      : one-cycle enable pulse; all timing is counted in ticks.
//               It is a plain qualifier with no handshake or backpressure.
//               A cycle with tick=0 is ignored by the controller.
//   sa, sb    : car-present levels for streets A and B, sampled on tick only
//   la, lb    : lamp groups {red, yellow, green}, one-hot
//   sel       : right-of-way select, 0 = A side, 1 = B side
//   dbg_state : current FSM state. Encoding: 0 A_GREEN, 1 A_YELLOW,
//               2 AR_TO_B, 3 B_GREEN, 4 B_YELLOW, 5 AR_TO_A
//   dbg_cnt   : ticks spent in the current state
//
//   master : the side that drives tick/sensors (environment)
//   slave  : the controller
interface traffic_light_if;
  logic       tick;
  logic       sa;
  logic       sb;
  logic [2:0] la;
  logic [2:0] lb;
  logic       sel;
  logic [2:0] dbg_state;
  logic [7:0] dbg_cnt;

  modport master (
    output tick, sa, sb,
    input  la, lb, sel, dbg_state, dbg_cnt
  );

  modport slave (
    input  tick, sa, sb,
    output la, lb, sel, dbg_state, dbg_cnt
  );
endinterface

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
//   Moore controller for a two-street intersection. The state cycles
//   A_GREEN -> A_YELLOW -> AR_TO_B -> B_GREEN -> B_YELLOW -> AR_TO_A.
//   Green lasts at least MIN_GREEN ticks and is extended while the
//   street's own sensor is high; yellow and all-red states have fixed
//   durations. Lamps and sel are decoded from the state register only.
//
//   Ports:
//     clk   : system clock, rising edge
//     reset : asynchronous, active-high; forces A_GREEN, cnt=0
//     bus   : traffic_light_if.slave (tick, sa, sb in; la, lb, sel,
//             dbg_state, dbg_cnt out)
module traffic_light_fsm #(
  parameter int MIN_GREEN    = 5,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1
) (
  input  logic             clk,
  input  logic             reset,
  traffic_light_if.slave   bus
);

  localparam logic [2:0] A_GREEN  = 3'd0;
  localparam logic [2:0] A_YELLOW = 3'd1;
  localparam logic [2:0] AR_TO_B  = 3'd2;
  localparam logic [2:0] B_GREEN  = 3'd3;
  localparam logic [2:0] B_YELLOW = 3'd4;
  localparam logic [2:0] AR_TO_A  = 3'd5;

  // Last count value of each state; reaching it on a tick ends the state.
  localparam logic [7:0] GREEN_LAST  = 8'(MIN_GREEN - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TICKS - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TICKS - 1);

  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      A_GREEN: begin
        if (bus.tick) begin
          if (cnt_q < GREEN_LAST) begin
            cnt_d = cnt_q + 8'd1;
          end else if (!bus.sa) begin
            state_d = A_YELLOW;
            cnt_d   = 8'd0;
          end
          // Sensor high after the minimum: hold, cnt stays saturated.
        end
      end
      A_YELLOW: begin
        if (bus.tick) begin
          if (cnt_q >= YELLOW_LAST) begin
            state_d = AR_TO_B;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      AR_TO_B: begin
        if (bus.tick) begin
          if (cnt_q >= ALLRED_LAST) begin
            state_d = B_GREEN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      B_GREEN: begin
        if (bus.tick) begin
          if (cnt_q < GREEN_LAST) begin
            cnt_d = cnt_q + 8'd1;
          end else if (!bus.sb) begin
            state_d = B_YELLOW;
            cnt_d   = 8'd0;
          end
        end
      end
      B_YELLOW: begin
        if (bus.tick) begin
          if (cnt_q >= YELLOW_LAST) begin
            state_d = AR_TO_A;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      AR_TO_A: begin
        if (bus.tick) begin
          if (cnt_q >= ALLRED_LAST) begin
            state_d = A_GREEN;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        // Unused encodings recover through all-red regardless of tick,
        // so A never goes green straight out of a corrupted state.
        state_d = AR_TO_A;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= A_GREEN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from the state register only; the async reset
  // of state_q makes the reset lamp pattern appear without a clock edge.
  always_comb begin
    bus.la  = LAMP_RED;
    bus.lb  = LAMP_RED;
    bus.sel = 1'b0;
    case (state_q)
      A_GREEN:  bus.la = LAMP_GREEN;
      A_YELLOW: bus.la = LAMP_YELLOW;
      AR_TO_B:  ;
      B_GREEN: begin
        bus.lb  = LAMP_GREEN;
        bus.sel = 1'b1;
      end
      B_YELLOW: begin
        bus.lb  = LAMP_YELLOW;
        bus.sel = 1'b1;
      end
      AR_TO_A:  bus.sel = 1'b1;
      default:  ;
    endcase
  end

  assign bus.dbg_state = state_q;
  assign bus.dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm
//   Directed bench for traffic_light_fsm with default parameters.
//   A table of {tick, sa, sb, expected state} records is applied one
//   clock per entry; lamp and select expectations come from the lamp
//   table below. Reset-in-flight and sparse-tick runs are hand-written.
module tb_traffic_light_fsm;

  localparam logic [2:0] AG  = 3'd0;
  localparam logic [2:0] AY  = 3'd1;
  localparam logic [2:0] ARB = 3'd2;
  localparam logic [2:0] BG  = 3'd3;
  localparam logic [2:0] BY  = 3'd4;
  localparam logic [2:0] ARA = 3'd5;

  typedef struct {
    logic       tick;
    logic       sa;
    logic       sb;
    logic [2:0] st;
  } vec_t;

  logic clk;
  logic reset;
  traffic_light_if bus ();

  traffic_light_fsm #(
    .MIN_GREEN(5), .YELLOW_TICKS(3), .ALLRED_TICKS(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  vec_t        vecs[$];
  logic [9:0]  exp_q[$];   // {state, la, lb, sel}
  logic [2:0]  fr[0:18];   // free-run state after k ticks

  // Lamp pattern {la, lb, sel} for a state.
  function automatic logic [6:0] lamps(input logic [2:0] st);
    case (st)
      AG:      lamps = {3'b001, 3'b100, 1'b0};
      AY:      lamps = {3'b010, 3'b100, 1'b0};
      ARB:     lamps = {3'b100, 3'b100, 1'b0};
      BG:      lamps = {3'b100, 3'b001, 1'b1};
      BY:      lamps = {3'b100, 3'b010, 1'b1};
      default: lamps = {3'b100, 3'b100, 1'b1};
    endcase
  endfunction

  task automatic check(input string name, input logic [11:0] act,
                       input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic add_vec(input logic t, input logic a, input logic b,
                         input logic [2:0] st);
    vec_t v;
    v.tick = t; v.sa = a; v.sb = b; v.st = st;
    vecs.push_back(v);
    exp_q.push_back({st, lamps(st)});
  endtask

  task automatic drive(input logic t, input logic a, input logic b);
    bus.tick = t;
    bus.sa   = a;
    bus.sb   = b;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [2:0] st);
    logic [6:0] l;
    l = lamps(st);
    check({name, ".state"}, 12'(bus.dbg_state), 12'(st));
    check({name, ".la"},    12'(bus.la),        12'(l[6:4]));
    check({name, ".lb"},    12'(bus.lb),        12'(l[3:1]));
    check({name, ".sel"},   12'(bus.sel),       12'(l[0]));
  endtask

  // ---------------- per-cycle invariants ----------------
  always @(negedge clk) begin
    check("inv.la_onehot", 12'($onehot(bus.la)), 12'd1);
    check("inv.lb_onehot", 12'($onehot(bus.lb)), 12'd1);
    check("inv.one_side_red",
          12'((bus.la == 3'b100) || (bus.lb == 3'b100)), 12'd1);
    check("inv.sel",
          12'(bus.sel),
          12'((bus.dbg_state == BG) || (bus.dbg_state == BY) ||
              (bus.dbg_state == ARA)));
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    fr = '{AG, AG, AG, AG, AG, AY, AY, AY, ARB,
           BG, BG, BG, BG, BG, BY, BY, BY, ARA, AG};

    // Free run: tick every cycle, no cars. 5/3/1/5/3/1, period 18.
    for (int k = 1; k <= 18; k++) add_vec(1'b1, 1'b0, 1'b0, fr[k]);
    // Sensor hold on A for 20 ticks; sb toggling is ignored.
    for (int i = 0; i < 20; i++) add_vec(1'b1, 1'b1, 1'(i % 2), AG);
    // sa drops on a non-tick cycle: no effect until a tick.
    add_vec(1'b0, 1'b0, 1'b1, AG);
    add_vec(1'b0, 1'b1, 1'b0, AG);
    // First tick with sa low exits green (sb high is ignored).
    add_vec(1'b1, 1'b0, 1'b1, AY);
    add_vec(1'b1, 1'b0, 1'b0, AY);
    add_vec(1'b1, 1'b1, 1'b0, AY);
    add_vec(1'b1, 1'b0, 1'b0, ARB);
    add_vec(1'b1, 1'b0, 1'b0, BG);
    // Minimum green: sb=1 only on ticks 2..4, exit on tick 5.
    add_vec(1'b1, 1'b1, 1'b0, BG);
    add_vec(1'b1, 1'b0, 1'b1, BG);
    add_vec(1'b1, 1'b1, 1'b1, BG);
    add_vec(1'b1, 1'b0, 1'b1, BG);
    add_vec(1'b1, 1'b0, 1'b0, BY);
    // tick=0 freezes state and counter.
    for (int i = 0; i < 3; i++) add_vec(1'b0, 1'b1, 1'b1, BY);
    add_vec(1'b1, 1'b0, 1'b0, BY);
    add_vec(1'b1, 1'b0, 1'b0, BY);
    add_vec(1'b1, 1'b0, 1'b0, ARA);
    add_vec(1'b0, 1'b1, 1'b1, ARA);
    add_vec(1'b1, 1'b0, 1'b0, AG);

    // Reset
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check_outputs("reset", AG);
    check("reset.cnt", 12'(bus.dbg_cnt), 12'd0);
    step();
    step();
    reset = 1'b0;

    // Table-driven run.
    foreach (vecs[i]) begin
      logic [9:0] e;
      drive(vecs[i].tick, vecs[i].sa, vecs[i].sb);
      step();
      e = exp_q.pop_front();
      check_outputs($sformatf("vec%0d", i), e[9:7]);
    end
    check("table.cnt_after", 12'(bus.dbg_cnt), 12'd0);

    // Reset asserted between edges in the middle of B_YELLOW.
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) step();
    check_outputs("pre_reset", BY);
    check("pre_reset.cnt", 12'(bus.dbg_cnt), 12'd1);
    drive(1'b0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_outputs("async_reset", AG);
    check("async_reset.cnt", 12'(bus.dbg_cnt), 12'd0);
    step();
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_outputs($sformatf("post_reset%0d", k), AG);
      check("post_reset.cnt", 12'(bus.dbg_cnt), 12'(k));
    end
    step();
    check_outputs("post_reset5", AY);

    // Sparse tick: one tick every 4th cycle; state follows the free-run
    // sequence indexed by the number of ticks seen so far.
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 72; e++) begin
      drive(1'((e % 4) == 0), 1'b0, 1'b0);
      step();
      check_outputs($sformatf("sparse%0d", e), fr[e / 4]);
    end

    drive(1'b0, 1'b0, 1'b0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Moore state machine for a two-street intersection, driven by a slow tick enable and two car sensors. It sequences green → yellow → all-red for streets A and B, and generates the right-of-way select that feeds the downstream 2:1 light-pattern multiplexer. It also drives both lamp groups directly. All timing is counted in ticks, never in raw clock cycles.

## Interface
Parameters:
- MIN_GREEN, 5, minimum ticks a street stays green; legal range 1..255
- YELLOW_TICKS, 3, ticks spent in each yellow state; legal range 1..255
- ALLRED_TICKS, 1, ticks spent in each all-red state; legal range 1..255

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; one clock domain only
- tick  input  1  single-cycle enable pulse (e.g. 1 Hz), synchronous to clk
- sa  input  1  car present on street A (synchronous, level)
- sb  input  1  car present on street B (synchronous, level)
- la  output  3  street A lamps, encoding {red, yellow, green}, exactly one bit set
- lb  output  3  street B lamps, same encoding
- sel  output  1  right-of-way select to the downstream mux; 0 = A side, 1 = B side

## Operation
- States: A_GREEN, A_YELLOW, AR_TO_B, B_GREEN, B_YELLOW, AR_TO_A. The sequence is cyclic in that order.
- Counter cnt: 8 bits, counts ticks spent in the current state. It is cleared to 0 on every state transition and changes only on cycles with tick=1.
- Timed states (A_YELLOW, AR_TO_B, B_YELLOW, AR_TO_A) with duration D:
  - On a tick with cnt==D-1: advance to the next state and set cnt←0.
  - On any other tick: cnt←cnt+1.
- Green states (A_GREEN with sensor sa; B_GREEN with sensor sb):
  - On a tick with cnt<MIN_GREEN-1: cnt←cnt+1.
  - On a tick with cnt==MIN_GREEN-1 and the own sensor low: advance to yellow and set cnt←0.
  - On a tick with cnt==MIN_GREEN-1 and the own sensor high: hold the state; cnt saturates at MIN_GREEN-1.
  - Once the minimum has elapsed, the first tick with the sensor low exits green.
- Cross-street sensor (sb in A_GREEN, sa in B_GREEN) is ignored. Green is never preempted.
- Lamp decode (Moore, from the state register only):
  - A_GREEN: la=001, lb=100
  - A_YELLOW: la=010, lb=100
  - AR_TO_B: la=100, lb=100
  - B_GREEN: la=100, lb=001
  - B_YELLOW: la=100, lb=010
  - AR_TO_A: la=100, lb=100
- sel=1 in B_GREEN, B_YELLOW and AR_TO_A; sel=0 in all other states.
- Illegal or unused state encodings recover to AR_TO_A with cnt=0 on the next clock. This gives a safe all-red before A goes green.

## Timing
- Reset asserted, at any time and in any state, forces all of the following immediately, without waiting for a clock edge:
  - state=A_GREEN, cnt=0
  - la=001, lb=100, sel=0
- Reset deassertion: the first rising edge with reset=0 may already act on tick.
- Outputs change on the same clk edge as the state, with no extra pipeline stage and no combinational path from inputs to outputs.
- Sensors are sampled only on tick cycles. A sensor pulse that does not overlap a tick has no effect.
- tick=0 freezes both state and cnt.
- Dwell times, with the sensor low at the deciding tick:
  - green: exactly MIN_GREEN ticks
  - yellow: exactly YELLOW_TICKS ticks
  - all-red: exactly ALLRED_TICKS ticks
- With tick tied high and sa=sb=0, the full cycle is 2*(MIN_GREEN+YELLOW_TICKS+ALLRED_TICKS) clocks, which is 18 with the defaults.
- Parameter value 1: the state lasts one tick, so it exits on the first tick after entry.

## Test plan
- Reset check: assert reset mid-B_YELLOW between clock edges → la=001, lb=100 and sel=0 immediately, before the next clock edge. After release, cnt starts from 0.
- Free-run: tick=1 every cycle, sa=sb=0, default parameters → state holds for 5/3/1/5/3/1 cycles. sel rises on the edge entering B_GREEN and falls on the edge entering A_GREEN. Period is 18 cycles.
- Sensor hold: sa=1 for 20 ticks, then sa=0 → A_GREEN persists for all 20 ticks and exits to A_YELLOW on the first tick with sa=0. sb toggling during this window has no effect.
- Sparse tick: tick every 4th cycle, sa=sb=0 → each dwell time is a multiple of 4 cycles (A_GREEN 20 cycles). State never changes on a cycle with tick=0.
- Minimum green: sb=0 on entry to B_GREEN, then sb=1 from tick 2 to tick 4, then sb=0 → B_GREEN lasts exactly 5 ticks; the sensor does not extend it past the minimum.
- Invariants, checked on every cycle: la and lb are each one-hot; la and lb are never both non-red; sel==1 exactly in B_GREEN, B_YELLOW and AR_TO_A.
